// File: rtl/audio_conditioner_if.sv
// Audio conditioner bus: raw core samples and controls in, captured HDMI-side
// samples, sample clock, strobe and clip status out.
interface audio_conditioner_if #(
  parameter int CHANNELS  = 2,
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 16,
  parameter int VOL_BITS  = 2
);

  logic [CHANNELS*IN_WIDTH-1:0]  audio_in;
  logic [VOL_BITS-1:0]           volume;
  logic                          clip_clr;
  logic [CHANNELS*OUT_WIDTH-1:0] audio_out;
  logic                          audio_clk;
  logic                          sample_strobe;
  logic [CHANNELS-1:0]           clip;

  // Side that supplies samples and controls (core / testbench).
  modport master (
    output audio_in,
    output volume,
    output clip_clr,
    input  audio_out,
    input  audio_clk,
    input  sample_strobe,
    input  clip
  );

  // The conditioner itself.
  modport slave (
    input  audio_in,
    input  volume,
    input  clip_clr,
    output audio_out,
    output audio_clk,
    output sample_strobe,
    output clip
  );

endinterface

// File: rtl/audio_conditioner.sv
// N-channel audio back-end: pre-shift and saturate each raw sample, apply a
// ramped power-of-two volume, and capture all channels together on the rising
// edge of a fractional-NCO generated sample clock.
module audio_conditioner #(
  parameter int CHANNELS  = 2,
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 16,
  parameter int PRESHIFT  = 1,
  parameter int VOL_BITS  = 2,
  parameter int CLK_HZ    = 32000000,
  parameter int RATE_HZ   = 48000
) (
  input  logic               clk,
  input  logic               reset,
  audio_conditioner_if.slave bus
);

  // The NCO ticks twice per output sample (once per audio_clk half period).
  localparam int INC   = 2 * RATE_HZ;
  localparam int ACC_W = $clog2(CLK_HZ + INC);

  localparam logic [ACC_W:0] INC_W = (ACC_W + 1)'(INC);
  localparam logic [ACC_W:0] CLK_W = (ACC_W + 1)'(CLK_HZ);

  localparam logic [VOL_BITS-1:0] VOL_MAX = {VOL_BITS{1'b1}};

  // Saturation limits expressed at input width so the comparison is exact.
  localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
    {{(IN_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
    {{(IN_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W:0]      acc_sum;
  logic [ACC_W:0]      acc_wrap;
  logic                tick;
  logic                capture;
  logic                audio_clk_q;
  logic                strobe_q;
  logic [VOL_BITS-1:0] cur_vol_q;
  logic [VOL_BITS-1:0] cur_vol_d;
  logic [VOL_BITS-1:0] shamt;

  // Phase accumulator: add 2*RATE each clk, wrap by CLK_HZ and tick on wrap,
  // which gives an exact long-term average rate.
  always_comb begin
    acc_sum  = {1'b0, acc_q} + INC_W;
    acc_wrap = acc_sum - CLK_W;
    tick     = (acc_sum >= CLK_W);
    acc_d    = tick ? acc_wrap[ACC_W-1:0] : acc_sum[ACC_W-1:0];
  end

  // A tick while audio_clk is low is the one that raises it: that is a capture.
  assign capture = tick & ~audio_clk_q;

  // NCO state, sample clock and the one-cycle capture strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      audio_clk_q <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      strobe_q <= capture;
      if (tick) begin
        audio_clk_q <= ~audio_clk_q;
      end
    end
  end

  // Volume ramp: one step toward the target per captured sample, so a target
  // change mid-ramp simply redirects the next step.
  always_comb begin
    cur_vol_d = cur_vol_q;
    if (capture) begin
      if (cur_vol_q < bus.volume) begin
        cur_vol_d = cur_vol_q + 1'b1;
      end else if (cur_vol_q > bus.volume) begin
        cur_vol_d = cur_vol_q - 1'b1;
      end
    end
  end

  // Current applied volume; starts muted so the output fades in after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_vol_q <= '0;
    end else begin
      cur_vol_q <= cur_vol_d;
    end
  end

  // Full volume is a shift of zero; each step down halves the level.
  assign shamt = VOL_MAX - cur_vol_q;

  assign bus.audio_clk     = audio_clk_q;
  assign bus.sample_strobe = strobe_q;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic signed [IN_WIDTH-1:0]  x;
      logic                        sat_hi;
      logic                        sat_lo;
      logic signed [OUT_WIDTH-1:0] s1_d;
      logic signed [OUT_WIDTH-1:0] s1_q;
      logic signed [OUT_WIDTH-1:0] s2_d;
      logic signed [OUT_WIDTH-1:0] s2_q;
      logic signed [OUT_WIDTH-1:0] out_q;
      logic                        clip_d;
      logic                        clip_q;

      // Pre-shift then clamp; the arithmetic shift keeps the sign, so the most
      // negative input lands on the negative rail rather than wrapping.
      always_comb begin
        x      = $signed(bus.audio_in[gi*IN_WIDTH +: IN_WIDTH]) >>> PRESHIFT;
        sat_hi = (x > SAT_MAX);
        sat_lo = (x < SAT_MIN);
        if (sat_hi) begin
          s1_d = OUT_MAX;
        end else if (sat_lo) begin
          s1_d = OUT_MIN;
        end else begin
          s1_d = x[OUT_WIDTH-1:0];
        end
        // Fresh saturation takes priority over a simultaneous clear.
        clip_d = sat_hi | sat_lo | (clip_q & ~bus.clip_clr);
      end

      // Volume stage: mute at zero, otherwise a sign-preserving right shift.
      always_comb begin
        if (cur_vol_q == '0) begin
          s2_d = '0;
        end else begin
          s2_d = s1_q >>> shamt;
        end
      end

      // Two-stage sample pipeline, sticky clip flag and the captured output.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_q   <= '0;
          s2_q   <= '0;
          out_q  <= '0;
          clip_q <= 1'b0;
        end else begin
          s1_q   <= s1_d;
          s2_q   <= s2_d;
          clip_q <= clip_d;
          if (capture) begin
            out_q <= s2_q;
          end
        end
      end

      assign bus.audio_out[gi*OUT_WIDTH +: OUT_WIDTH] = out_q;
      assign bus.clip[gi]                             = clip_q;
    end
  endgenerate

endmodule

// File: tb/tb_audio_conditioner.sv
// Self-checking bench for audio_conditioner: sample-clock timing, a table of
// settled-volume vectors, ramp sequences, clip behaviour, async reset and a
// randomized run against an arithmetic reference model.
module tb_audio_conditioner;

  localparam int CH = 2;
  localparam int IW = 18;
  localparam int OW = 16;
  localparam int PS = 1;
  localparam int VB = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  audio_conditioner_if #(.CHANNELS(CH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .VOL_BITS(VB)) bus ();

  audio_conditioner #(
    .CHANNELS(CH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .PRESHIFT(PS),
    .VOL_BITS(VB), .CLK_HZ(32000000), .RATE_HZ(48000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  vol;
    logic [17:0] in0;
    logic [17:0] in1;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic [1:0]  exp_clip;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic set_in(input logic [17:0] a, input logic [17:0] b);
    bus.audio_in = {b, a};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Advance to the next capture strobe, bounded.
  task automatic wait_capture(input string tag);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.sample_strobe && c < 1000);
    if (!bus.sample_strobe) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no capture within %0d clk", tag, c);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic int sx(input logic [17:0] v);
    int r;
    r = int'(v);
    if (v[17]) r = r - (1 << 18);
    return r;
  endfunction

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic bit model_clip(input logic [17:0] raw);
    int x;
    x = fdiv(sx(raw), 1 << PS);
    return (x > 32767) || (x < -32768);
  endfunction

  function automatic logic [15:0] model_out(input logic [17:0] raw, input int vol);
    int x;
    x = fdiv(sx(raw), 1 << PS);
    if (x > 32767)  x = 32767;
    if (x < -32768) x = -32768;
    if (vol == 0) x = 0;
    else          x = fdiv(x, 1 << (((1 << VB) - 1) - vol));
    return 16'(x);
  endfunction

  function automatic logic [17:0] rand_in();
    logic [17:0] r;
    case ($urandom_range(0, 5))
      0:       r = 18'h1FFFF;
      1:       r = 18'h20000;
      2:       r = 18'h3FFFF;
      3:       r = 18'(32'h0FFFE + $urandom_range(0, 3));
      default: r = 18'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    int          n;
    int          last_edge;
    int          caps[$];
    logic        prev_clk;
    logic        rise;
    logic        tog;
    int          mvol;
    int          v;
    int          c;
    logic [17:0] a;
    logic [17:0] b;
    logic [15:0] ramp_up[5];
    logic [15:0] ramp_dn[5];

    vecs[0] = '{2'd3, 18'h1FFFF, 18'h20000, 16'h7FFF, 16'h8000, 2'b11};
    vecs[1] = '{2'd3, 18'h04000, 18'h3FFFE, 16'h2000, 16'hFFFF, 2'b00};
    vecs[2] = '{2'd1, 18'h3FFFE, 18'h3FFF8, 16'hFFFF, 16'hFFFF, 2'b00};
    vecs[3] = '{2'd2, 18'h0FFFE, 18'h30002, 16'h3FFF, 16'hC000, 2'b00};
    vecs[4] = '{2'd1, 18'h10000, 18'h2FFFF, 16'h1FFF, 16'hE000, 2'b11};
    vecs[5] = '{2'd0, 18'h1FFFF, 18'h12345, 16'h0000, 16'h0000, 2'b11};
    vecs[6] = '{2'd3, 18'h0FFFF, 18'h30000, 16'h7FFF, 16'h8000, 2'b00};
    vecs[7] = '{2'd2, 18'h00001, 18'h3FFFF, 16'h0000, 16'hFFFF, 2'b00};

    ramp_up = '{16'h0000, 16'h0800, 16'h1000, 16'h2000, 16'h2000};
    ramp_dn = '{16'h2000, 16'h1000, 16'h0800, 16'h0000, 16'h0000};

    bus.volume   = 2'd3;
    bus.clip_clr = 1'b0;
    set_in(18'h04000, 18'h20000);

    // ---- reset state ----
    #1;
    check("rst_audio_out", bus.audio_out, 32'h0);
    check("rst_audio_clk", bus.audio_clk, 1'b0);
    check("rst_strobe", bus.sample_strobe, 1'b0);
    check("rst_clip", bus.clip, 2'b00);

    // ---- sample clock timing ----
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    n         = 0;
    last_edge = 0;
    prev_clk  = 1'b0;
    while (caps.size() < 4 && n < 3000) begin
      @(negedge clk);
      n++;
      rise = bus.audio_clk & ~prev_clk;
      tog  = bus.audio_clk ^ prev_clk;
      if (tog) begin
        check($sformatf("seg_len_ok@%0d(len %0d)", n, n - last_edge),
              32'((n - last_edge) == 333 || (n - last_edge) == 334), 32'd1);
        last_edge = n;
      end
      if (rise || bus.sample_strobe) check($sformatf("strobe_eq_rise@%0d", n), bus.sample_strobe, rise);
      if (bus.sample_strobe) caps.push_back(n);
      prev_clk = bus.audio_clk;
    end
    if (caps.size() < 4) begin
      n_checks++;
      n_fail++;
      $display("FAIL timing: only %0d captures in %0d clk, required 4", caps.size(), n);
    end else begin
      check("first_capture_delay", caps[0], 334);
      check("cap_gap1", caps[1] - caps[0], 666);
      check("cap_gap2", caps[2] - caps[1], 667);
      check("cap_gap3", caps[3] - caps[2], 667);
      check("cap_3_samples", caps[3] - caps[0], 2000);
    end

    // ---- table of settled-volume vectors ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].in0, vecs[i].in1);
      bus.volume   = vecs[i].vol;
      bus.clip_clr = 1'b1;
      @(negedge clk);
      bus.clip_clr = 1'b0;
      for (int k = 0; k < 4; k++) wait_capture($sformatf("vec%0d", i));
      check($sformatf("vec%0d_ch0", i), bus.audio_out[15:0], vecs[i].exp0);
      check($sformatf("vec%0d_ch1", i), bus.audio_out[31:16], vecs[i].exp1);
      check($sformatf("vec%0d_clip", i), bus.clip, vecs[i].exp_clip);
    end

    // ---- clip clear in-range ----
    set_in(18'h00100, 18'h3FF00);
    bus.clip_clr = 1'b1;
    @(negedge clk);
    bus.clip_clr = 1'b0;
    @(negedge clk);
    check("clip_cleared", bus.clip, 2'b00);

    // ---- ramp up then down ----
    set_in(18'h04000, 18'h00000);
    bus.volume = 2'd3;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wait_capture("ramp_up");
      check($sformatf("ramp_up%0d", k), bus.audio_out[15:0], ramp_up[k]);
    end
    bus.volume = 2'd0;
    for (int k = 0; k < 5; k++) begin
      wait_capture("ramp_dn");
      check($sformatf("ramp_dn%0d", k), bus.audio_out[15:0], ramp_dn[k]);
    end

    // ---- saturation vs simultaneous clear ----
    set_in(18'h1FFFF, 18'h00000);
    bus.clip_clr = 1'b1;
    repeat (10) @(negedge clk);
    check("clip_sat_beats_clr", bus.clip, 2'b01);
    set_in(18'h00000, 18'h00000);
    bus.clip_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("clip_sticky", bus.clip, 2'b01);
    bus.clip_clr = 1'b1;
    @(negedge clk);
    bus.clip_clr = 1'b0;
    check("clip_clr_after_release", bus.clip, 2'b00);

    // ---- async reset mid-ramp ----
    set_in(18'h04000, 18'h20000);
    bus.volume = 2'd3;
    do_reset();
    wait_capture("pre_rst");
    wait_capture("pre_rst");
    check("pre_rst_out", bus.audio_out, 32'hE000_0800);
    repeat (100) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out", bus.audio_out, 32'h0);
    check("async_rst_clk", bus.audio_clk, 1'b0);
    check("async_rst_strobe", bus.sample_strobe, 1'b0);
    check("async_rst_clip", bus.clip, 2'b00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.sample_strobe && c < 1000);
    check("post_rst_first_cap", c, 334);
    check("post_rst_muted", bus.audio_out, 32'h0);
    wait_capture("post_rst2");
    check("post_rst_ramp", bus.audio_out, 32'hE000_0800);

    // ---- randomized run against the reference model ----
    do_reset();
    mvol = 0;
    for (int i = 0; i < 15; i++) begin
      a = rand_in();
      b = rand_in();
      v = int'($urandom_range(0, 3));
      set_in(a, b);
      bus.volume   = 2'(v);
      bus.clip_clr = 1'b1;
      @(negedge clk);
      bus.clip_clr = 1'b0;
      wait_capture("rand");
      check($sformatf("rand%0d_ch0(in %h vol %0d)", i, a, mvol), bus.audio_out[15:0], model_out(a, mvol));
      check($sformatf("rand%0d_ch1(in %h vol %0d)", i, b, mvol), bus.audio_out[31:16], model_out(b, mvol));
      check($sformatf("rand%0d_clip", i), bus.clip, {model_clip(b), model_clip(a)});
      if (mvol < v)      mvol = mvol + 1;
      else if (mvol > v) mvol = mvol - 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_conditioner.md
Name: audio_conditioner

Overview:
Parametrised audio back-end between the core's raw sound outputs and the HDMI audio sample interface. It does the following:
- Generalises the fixed stereo 18-to-16-bit conversion and 2-bit volume to N channels, arbitrary widths and any volume depth.
- Replaces the integer 48 kHz divider with an exact-average fractional NCO.
- Adds click-free volume ramping, registered sample capture and sticky per-channel clip flags.

Parameters:
CHANNELS, 2, number of audio channels (ch0 = left)
IN_WIDTH, 18, signed input sample width
OUT_WIDTH, 16, signed output sample width
PRESHIFT, 1, arithmetic right shift before saturation; IN_WIDTH-PRESHIFT >= OUT_WIDTH
VOL_BITS, 2, volume control width
CLK_HZ, 32000000, frequency of clk
RATE_HZ, 48000, output sample rate

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
audio_in  in  CHANNELS*IN_WIDTH  signed samples; ch k at bits [k*IN_WIDTH +: IN_WIDTH]
volume  in  VOL_BITS  target volume; 0 = mute, max = unity
clip_clr  in  1  clears all clip flags
audio_out  out  CHANNELS*OUT_WIDTH  captured signed samples, same packing
audio_clk  out  1  ~50% duty square wave at RATE_HZ average; rising edge marks a new sample
sample_strobe  out  1  one-cycle pulse in the cycle audio_out updates
clip  out  CHANNELS  sticky saturation flag per channel

Behaviour:
- Reset (async assert, sync release): acc, audio_out, audio_clk, sample_strobe, clip, cur_vol and all pipeline registers go to 0. Output is muted at start-up and fades in via the ramp.
- NCO, every clk:
  - If acc + 2*RATE_HZ >= CLK_HZ: acc <= acc + 2*RATE_HZ - CLK_HZ, and tick = 1.
  - Otherwise: acc <= acc + 2*RATE_HZ.
  - acc width is ceil(log2(CLK_HZ + 2*RATE_HZ)).
  - Each tick toggles audio_clk.
  - A tick that drives audio_clk 0->1 is a capture tick.
- Stage 1 (registered, every clk, per channel):
  - x = audio_in_k arithmetically shifted right by PRESHIFT.
  - If x > 2^(OUT_WIDTH-1)-1, s1 = that maximum. If x < -2^(OUT_WIDTH-1), s1 = that minimum. Otherwise s1 = x truncated to OUT_WIDTH.
  - A saturating cycle sets clip[k].
- Stage 2 (registered, every clk):
  - cur_vol = 0 gives s2 = 0.
  - Otherwise s2 = s1 arithmetically shifted right by (2^VOL_BITS-1 - cur_vol), sign-preserving.
  - Defaults therefore map 1 -> >>2, 2 -> >>1, 3 -> >>0.
- Input-to-s2 latency: 2 clk.
- Capture tick:
  - audio_out <= s2 (all channels in the same cycle), with sample_strobe = 1 for that cycle only.
  - audio_clk rises in the same cycle.
  - Between capture ticks, audio_out holds.
- Volume ramp:
  - On each capture tick, cur_vol moves one step toward volume: +1 if cur_vol < volume, -1 if cur_vol > volume, else hold.
  - The new cur_vol applies to stage 2 from the next clk, so the next captured sample uses it.
  - Volume changes mid-ramp retarget immediately; no overshoot.
- Clip flags:
  - Sticky until clip_clr.
  - A new saturation in the same cycle as clip_clr wins (flag stays 1).
- Boundaries:
  - The most negative input saturates correctly with no sign flip.
  - The shift of -1 at any volume stays -1 (arithmetic shift).
  - Reset mid-sample clears acc, so the phase restarts.
  - A reset pulse during a ramp returns cur_vol to 0.

Test Plan:
- Defaults, constant input, 3 capture ticks after reset -> capture ticks exactly 2000 clk apart over 3 samples (666/667/667 pattern). audio_clk high/low segments are 333 or 334 clk. sample_strobe is one cycle wide, coincident with each audio_clk rise.
- volume=3, audio_in ch0=18'h1FFFF, ch1=18'h20000, wait for ramp -> audio_out ch0=16'h7FFF, ch1=16'h8000. clip=2'b11. Pulse clip_clr with in-range input -> clip=2'b00.
- Ramp: volume=3 from reset, ch0 input 18'h04000 (x=16'h2000) -> successive captured ch0 values 0, 16'h0800, 16'h1000, 16'h2000, then stable. Then volume=0 -> 16'h1000, 16'h0800, 0.
- Negative shift: volume=1 settled, ch0=18'h3FFFE (x=-1) -> audio_out ch0=16'hFFFF. ch0=18'h3FFF8 (x=-4) -> 16'hFFFF.
- Simultaneous: hold a saturating input and assert clip_clr continuously -> clip stays 1. Release the saturating input -> clip clears on the next clip_clr.
- Async reset asserted mid-ramp, between clock edges -> all outputs 0 immediately. After release, the first capture occurs 334 clk later and ramps up from mute.
